// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : ALU control codes, FSM state type and op classification helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_BLEZ = 4'b1010;
  localparam logic [3:0] ALU_SRLV = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) ||
           (code == ALU_SRLV) || (code == ALU_LUI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module : alu_shifter
// Brief  : One-bit-per-cycle shifter (accumulator, counter, direction);
//          a combinational barrel shifter when ALU_FAST_SHIFT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_shifter #(
  parameter int WIDTH = 32
) (
`ifndef ALU_FAST_SHIFT_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic [WIDTH-1:0] step_out,
  output logic             last,
`endif
  input  logic             left,
  input  logic [WIDTH-1:0] din,
  input  logic [4:0]       count,
  output logic [WIDTH-1:0] out
);

`ifdef ALU_FAST_SHIFT_EN

  assign out = left ? (din << count) : (din >> count);

`else

  logic [WIDTH-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic             r_left;

  // A zero-count shift completes in the accept cycle, so it passes din through.
  assign out      = din;
  assign step_out = r_left ? {r_acc[WIDTH-2:0], 1'b0} : {1'b0, r_acc[WIDTH-1:1]};
  assign last     = (r_cnt == 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= 5'd0;
      r_left <= 1'b0;
    end else if (load) begin
      r_acc  <= din;
      r_cnt  <= count;
      r_left <= left;
    end else if (r_cnt != 5'd0) begin
      r_acc <= step_out;
      r_cnt <= r_cnt - 5'd1;
    end
  end

`endif

endmodule

`default_nettype wire

// File: rtl/alu_iter.sv
// ============================================================================
// Module : alu_iter
// Brief  : Multi-cycle ALU with start/done handshake and iterative shifter.
//          Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_t       r_state, w_state_n;
  logic [WIDTH-1:0] r_result, w_result_n;
  logic             r_zero, w_zero_n;
  logic             r_illegal, w_illegal_n;
  logic             r_done, w_done_n;

  logic [4:0]       w_count;
  logic             w_left;
  logic [WIDTH-1:0] w_shift_out;
  logic [WIDTH-1:0] w_op_res;
  logic             w_op_zero;
  logic             w_op_ill;
`ifndef ALU_FAST_SHIFT_EN
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_step;
`endif

  always_comb begin
    w_left = (alucontrol == ALU_SLL) || (alucontrol == ALU_LUI);
    case (alucontrol)
      ALU_SRLV: w_count = a[4:0];
      ALU_LUI:  w_count = 5'd16;
      default:  w_count = shamt;
    endcase
  end

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
`ifndef ALU_FAST_SHIFT_EN
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .step_out (w_step),
    .last     (w_last),
`endif
    .left     (w_left),
    .din      (b),
    .count    (w_count),
    .out      (w_shift_out)
  );

  // Result of any op that finishes in the accept cycle.
  always_comb begin
    w_op_res = '0;
    w_op_ill = 1'b0;
    case (alucontrol)
      ALU_AND:  w_op_res = a & b;
      ALU_OR:   w_op_res = a | b;
      ALU_ADD:  w_op_res = a + b;
      ALU_SUB:  w_op_res = a - b;
      ALU_SLT:  w_op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_XOR:  w_op_res = a ^ b;
      ALU_BLEZ: w_op_res = '0;
      ALU_SLL, ALU_SRL, ALU_SRLV, ALU_LUI: w_op_res = w_shift_out;
      default:  w_op_ill = 1'b1;
    endcase
    w_op_zero = (w_op_res == '0);
    if (alucontrol == ALU_BLEZ) begin
      w_op_zero = a[WIDTH-1] | (a == '0);
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_done_n    = 1'b0;
    w_result_n  = r_result;
    w_zero_n    = r_zero;
    w_illegal_n = r_illegal;
`ifndef ALU_FAST_SHIFT_EN
    w_load      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift(alucontrol) && (w_count != 5'd0)) begin
            w_load    = 1'b1;
            w_state_n = SHIFT;
          end else
`endif
          begin
            w_done_n    = 1'b1;
            w_result_n  = w_op_res;
            w_zero_n    = w_op_zero;
            w_illegal_n = w_op_ill;
          end
        end
      end
      SHIFT: begin
`ifndef ALU_FAST_SHIFT_EN
        if (w_last) begin
          w_state_n   = IDLE;
          w_done_n    = 1'b1;
          w_result_n  = w_step;
          w_zero_n    = (w_step == '0);
          w_illegal_n = 1'b0;
        end
`else
        w_state_n = IDLE;
`endif
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= w_done_n;
      r_result  <= w_result_n;
      r_zero    <= w_zero_n;
      r_illegal <= w_illegal_n;
    end
  end

  assign busy    = (r_state == SHIFT);
  assign done    = r_done;
  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
// ============================================================================
// Module : tb_alu_iter
// Brief  : Self-checking bench for alu_iter: directed table, corner sequences
//          and randomized ops against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  code;
    logic [31:0] av;
    logic [31:0] bv;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zr;
    logic        il;
    int          k;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input int k);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (k == 0) ? 1 : k + 1;
`endif
  endfunction

  // Behavioural model straight from the op table; k is the shift distance.
  task automatic ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, output logic [31:0] res, output logic zr,
                         output logic il, output int k);
    k   = 0;
    il  = 1'b0;
    res = 32'd0;
    case (c)
      4'd0:  res = x & y;
      4'd1:  res = x | y;
      4'd2:  res = x + y;
      4'd6:  res = x - y;
      4'd7:  res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  res = x ^ y;
      4'd10: res = 32'd0;
      4'd3:  begin res = y << s;      k = int'(s);      end
      4'd12: begin res = y >> s;      k = int'(s);      end
      4'd11: begin res = y >> x[4:0]; k = int'(x[4:0]); end
      4'd8:  begin res = y << 16;     k = 16;           end
      default: il = 1'b1;
    endcase
    zr = (c == 4'd10) ? ($signed(x) <= 0) : (res == 32'd0);
  endtask

  // Issue one op; returns outputs sampled in the done cycle, latency and busy count.
  task automatic run_op(input logic [3:0] code, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [4:0] sh, output logic [31:0] res, output logic zr,
                        output logic il, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; alucontrol = code; a = ai; b = bi; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0; alucontrol = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) begin
      errors++; checks++;
      $display("FAIL timeout: no done within %0d cycles (code %0h)", lat, code);
    end
    chk("busy_in_done", busy, 1'b0);
    res = result; zr = zero; il = illegal;
  endtask

  logic [31:0] r_res, m_res;
  logic        r_zr, r_il, m_zr, m_il;
  int          lat, bcnt, k;

  initial begin
    vecs[0]  = '{"add",    4'b0010, 32'd7,        32'd5,        5'd0,  32'd12,         1'b0, 1'b0, 0};
    vecs[1]  = '{"sub",    4'b0110, 32'd5,        32'd5,        5'd0,  32'd0,          1'b1, 1'b0, 0};
    vecs[2]  = '{"slt",    4'b0111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,          1'b0, 1'b0, 0};
    vecs[3]  = '{"blez0",  4'b1010, 32'd0,        32'd9,        5'd0,  32'd0,          1'b1, 1'b0, 0};
    vecs[4]  = '{"blez3",  4'b1010, 32'd3,        32'd0,        5'd0,  32'd0,          1'b0, 1'b0, 0};
    vecs[5]  = '{"sll31",  4'b0011, 32'd0,        32'd1,        5'd31, 32'h80000000,   1'b0, 1'b0, 31};
    vecs[6]  = '{"srl0",   4'b1100, 32'd0,        32'hABCD1234, 5'd0,  32'hABCD1234,   1'b0, 1'b0, 0};
    vecs[7]  = '{"srlv",   4'b1011, 32'd4,        32'hF0,       5'd0,  32'h0F,         1'b0, 1'b0, 4};
    vecs[8]  = '{"lui",    4'b1000, 32'd0,        32'h1234,     5'd0,  32'h12340000,   1'b0, 1'b0, 16};
    vecs[9]  = '{"ill",    4'b1110, 32'd3,        32'd4,        5'd0,  32'd0,          1'b1, 1'b1, 0};
    vecs[10] = '{"and",    4'b0000, 32'hF0F0FFFF, 32'h0FF0F00F, 5'd0,  32'h00F0F00F,   1'b0, 1'b0, 0};
    vecs[11] = '{"or",     4'b0001, 32'h00FF0000, 32'h0000FF01, 5'd0,  32'h00FFFF01,   1'b0, 1'b0, 0};
    vecs[12] = '{"xor",    4'b1001, 32'hAAAA5555, 32'hAAAA5555, 5'd0,  32'd0,          1'b1, 1'b0, 0};
    vecs[13] = '{"srl_to0",4'b1100, 32'd0,        32'h4,        5'd3,  32'd0,          1'b1, 1'b0, 3};

    reset = 1'b1; start = 1'b0; alucontrol = 4'd0; a = '0; b = '0; shamt = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].code, vecs[i].av, vecs[i].bv, vecs[i].sh, r_res, r_zr, r_il, lat, bcnt);
      chk({vecs[i].nm, "_result"},  r_res, vecs[i].res);
      chk({vecs[i].nm, "_zero"},    r_zr, vecs[i].zr);
      chk({vecs[i].nm, "_illegal"}, r_il, vecs[i].il);
      chk({vecs[i].nm, "_latency"}, lat, exp_lat(vecs[i].k));
      chk({vecs[i].nm, "_busycyc"}, bcnt, exp_lat(vecs[i].k) - 1);
    end

    // done is a single-cycle pulse and result holds afterwards
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("result_hold", result, 32'd0);

`ifndef ALU_FAST_SHIFT_EN
    // start while busy must be ignored, not queued
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b0011; b = 32'd1; shamt = 5'd8;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; alucontrol = 4'b0010; a = 32'd1; b = 32'd1;
    @(negedge clk); start = 1'b0;
    lat = 5;
    while (!done && lat < 50) begin @(negedge clk); lat++; end
    chk("busy_ign_latency", lat, 9);
    chk("busy_ign_result", result, 32'h100);
    repeat (4) begin
      @(negedge clk);
      chk("busy_ign_no_extra_done", done, 1'b0);
    end
`endif

    // reset in the middle of a long shift aborts it
    run_op(4'b0010, 32'd7, 32'd5, 5'd0, r_res, r_zr, r_il, lat, bcnt);
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b0011; b = 32'd1; shamt = 5'd31;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", zero, 1'b0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done) chk("abort_no_done", done, 1'b0);
    end
    chk("abort_result_after", result, 32'd0);
    run_op(4'b0110, 32'd100, 32'd58, 5'd0, r_res, r_zr, r_il, lat, bcnt);
    chk("post_abort_result", r_res, 32'd42);
    chk("post_abort_latency", lat, 1);

    // randomized ops against the behavioural model
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  c;
      logic [31:0] x, y;
      logic [4:0]  s;
      c = 4'($urandom);
      x = $urandom; y = $urandom; s = 5'($urandom);
      if (i % 4 == 0) x = x >> $urandom_range(31, 0);
      ref_alu(c, x, y, s, m_res, m_zr, m_il, k);
      run_op(c, x, y, s, r_res, r_zr, r_il, lat, bcnt);
      chk("rnd_result", r_res, m_res);
      chk("rnd_zero", r_zr, m_zr);
      chk("rnd_illegal", r_il, m_il);
      chk("rnd_latency", lat, exp_lat(k));
      chk("rnd_busycyc", bcnt, exp_lat(k) - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
